// File: rtl/hist_equalizer.sv
// Histogram-equalisation stage: builds an 8-bit LUT from a streamed CDF with an
// iterative divider into a shadow bank, swaps it in at frame start and remaps grey pixels.
module hist_equalizer #(
    parameter int unsigned CDF_W = 20
) (
    input  logic             iPclk,
    input  logic             iRST_N,
    input  logic             iCdf_Valid,
    input  logic [7:0]       iCdf_Addr,
    input  logic [CDF_W-1:0] iCdf_Data,
    input  logic             iCdf_Last,
    input  logic             iFval,
    input  logic             iDval,
    input  logic [7:0]       iGrey,
    output logic [7:0]       oGrey,
    output logic             oDval,
    output logic             oFval,
    output logic             oLut_Ready,
    output logic             oBusy,
    output logic [1:0]       oState
);

    localparam int unsigned NUM_W = CDF_W + 8;
    localparam int unsigned CNT_W = $clog2(NUM_W + 2);
    localparam logic [CNT_W-1:0] CNT_RD  = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_DV0 = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_DVN = CNT_W'(NUM_W);
    localparam logic [CNT_W-1:0] CNT_WR  = CNT_W'(NUM_W + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_CALC = 2'd2;
    localparam logic [1:0] S_PEND = 2'd3;

    logic [1:0]       state;
    logic [1:0]       next_state;
    logic             busy_nxt;

    logic [CDF_W-1:0] staging [256];
    logic [7:0]       lut     [512];
    logic [CDF_W-1:0] rd_data;
    logic [7:0]       lut_rd;

    logic [CDF_W-1:0] denom;
    logic [NUM_W-1:0] num;
    logic [CDF_W-1:0] rem;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       idx;

    logic             bank_sel;
    logic             lut_valid;
    logic             fval_prev;

    logic             fval_rise;
    logic             swap;
    logic             bank_sel_nxt;
    logic             lut_valid_nxt;
    logic             cdf_wr;
    logic             calc_div;
    logic             calc_wr;

    logic [NUM_W-1:0] num_src;
    logic [CDF_W-1:0] rem_src;
    logic [CDF_W:0]   trial;
    logic             q_bit;
    logic [CDF_W-1:0] rem_nxt;
    logic [NUM_W-1:0] num_nxt;
    logic [7:0]       lut_wdata;

    logic [7:0]       s1_grey;
    logic             s1_dval;
    logic             s1_fval;
    logic             s1_use;

    // Frame-start detection and the bank/valid values that take effect this cycle
    always_comb begin
        fval_rise     = iFval & ~fval_prev;
        swap          = (state == S_PEND) & fval_rise;
        bank_sel_nxt  = bank_sel ^ swap;
        lut_valid_nxt = lut_valid | swap;
        cdf_wr        = iCdf_Valid & (state != S_CALC);
        calc_div      = (state == S_CALC) && (cnt >= CNT_DV0) && (cnt <= CNT_DVN);
        calc_wr       = (state == S_CALC) && (cnt == CNT_WR);
    end

    // Next-state and registered-output decode
    always_comb begin
        next_state = state;
        busy_nxt   = 1'b0;
        case (state)
            S_IDLE, S_LOAD: begin
                if (iCdf_Valid) next_state = iCdf_Last ? S_CALC : S_LOAD;
            end
            S_CALC: begin
                if (calc_wr && (idx == 8'hFF)) next_state = S_PEND;
            end
            S_PEND: begin
                if (iCdf_Valid)  next_state = iCdf_Last ? S_CALC : S_LOAD;
                else if (swap)   next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
        busy_nxt = (next_state == S_LOAD) || (next_state == S_CALC);
    end

    always_ff @(posedge iPclk) begin
        if (!iRST_N) begin
            state  <= S_IDLE;
            oState <= S_IDLE;
            oBusy  <= 1'b0;
        end else begin
            state  <= next_state;
            oState <= next_state;
            oBusy  <= busy_nxt;
        end
    end

    // One restoring-divide step; the first step seeds from the freshly read CDF bin
    always_comb begin
        num_src   = (cnt == CNT_DV0) ? NUM_W'(rd_data) * NUM_W'(8'd255) : num;
        rem_src   = (cnt == CNT_DV0) ? '0 : rem;
        trial     = {rem_src, num_src[NUM_W-1]};
        q_bit     = trial >= {1'b0, denom};
        rem_nxt   = q_bit ? CDF_W'(trial - {1'b0, denom}) : trial[CDF_W-1:0];
        num_nxt   = {num_src[NUM_W-2:0], q_bit};
        lut_wdata = (denom == '0)      ? idx :
                    (|num[NUM_W-1:8])  ? 8'hFF : num[7:0];
    end

    always_ff @(posedge iPclk) begin
        if (!iRST_N) begin
            denom     <= '0;
            num       <= '0;
            rem       <= '0;
            cnt       <= '0;
            idx       <= '0;
            bank_sel  <= 1'b0;
            lut_valid <= 1'b0;
            fval_prev <= 1'b0;
        end else begin
            fval_prev <= iFval;
            bank_sel  <= bank_sel_nxt;
            lut_valid <= lut_valid_nxt;
            if (cdf_wr && iCdf_Last) begin
                denom <= iCdf_Data;
                cnt   <= '0;
                idx   <= '0;
            end else if (state == S_CALC) begin
                if (calc_wr) begin
                    cnt <= '0;
                    idx <= idx + 8'd1;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
                if (calc_div) begin
                    num <= num_nxt;
                    rem <= rem_nxt;
                end
            end
        end
    end

    // Storage: CDF staging, LUT write into the shadow bank, LUT read from the live bank
    always_ff @(posedge iPclk) begin
        if (cdf_wr) staging[iCdf_Addr] <= iCdf_Data;
        if ((state == S_CALC) && (cnt == CNT_RD)) rd_data <= staging[idx];
        if (calc_wr) lut[{~bank_sel, idx}] <= lut_wdata;
        lut_rd <= lut[{bank_sel_nxt, iGrey}];
    end

    // Two-stage pixel pipeline
    always_ff @(posedge iPclk) begin
        if (!iRST_N) begin
            s1_grey    <= '0;
            s1_dval    <= 1'b0;
            s1_fval    <= 1'b0;
            s1_use     <= 1'b0;
            oGrey      <= '0;
            oDval      <= 1'b0;
            oFval      <= 1'b0;
            oLut_Ready <= 1'b0;
        end else begin
            s1_grey    <= iGrey;
            s1_dval    <= iDval;
            s1_fval    <= iFval;
            s1_use     <= lut_valid_nxt;
            oGrey      <= s1_dval ? (s1_use ? lut_rd : s1_grey) : 8'd0;
            oDval      <= s1_dval;
            oFval      <= s1_fval;
            oLut_Ready <= swap;
        end
    end

endmodule

// File: doc/hist_equalizer.md
# hist_equalizer

Histogram-equalisation stage directly downstream of the histogram block. It accepts the 256-entry cumulative histogram (CDF) streamed out during blanking and computes an equalisation LUT with an iterative divider into a shadow bank. It swaps that bank in at the next frame start and remaps the live grey pixel stream through the active LUT. Output feeds the VGA/display path in place of raw grey.

## Interface
- CDF_W, 20, width of CDF entries and of the denominator
- iPclk  in  1  pixel clock; all logic on rising edge
- iRST_N  in  1  synchronous, active-low reset
- iCdf_Valid  in  1  CDF beat strobe
- iCdf_Addr  in  8  CDF bin index
- iCdf_Data  in  CDF_W  cumulative count for bin
- iCdf_Last  in  1  final beat; qualified by iCdf_Valid
- iFval  in  1  frame valid
- iDval  in  1  pixel valid
- iGrey  in  8  input grey pixel
- oGrey  out  8  equalised pixel
- oDval  out  1  iDval delayed 2 cycles
- oFval  out  1  iFval delayed 2 cycles
- oLut_Ready  out  1  one-cycle pulse when a new LUT goes active
- oBusy  out  1  high in LOAD or CALC
- oState  out  2  FSM state (0 IDLE, 1 LOAD, 2 CALC, 3 PEND)

## Operation
- Storage: staging RAM 256×CDF_W; two LUT banks 256×8; bank_sel, lut_valid flags.
- FSM:
  - IDLE: first iCdf_Valid writes staging[iCdf_Addr] -> LOAD.
  - LOAD: each iCdf_Valid writes staging[iCdf_Addr]. Order is free; duplicate addresses overwrite. Beat with iCdf_Last also writes, latches denom = iCdf_Data -> CALC, idx=0.
  - CALC: per idx: 1 read cycle, then num = staging[idx]*255 (CDF_W+8 bits), restoring divide num/denom, 1 quotient bit per cycle (CDF_W+8 cycles), then 1 write cycle into bank ~bank_sel. Quotient >255 saturates to 255. denom==0 writes entry = idx (identity). After idx 255 -> PEND. iCdf_Valid ignored in CALC.
  - PEND: on iFval rising edge (iFval=1, previous sample 0): bank_sel toggles, lut_valid=1, oLut_Ready pulses, -> IDLE. iCdf_Valid in PEND discards pending table, writes the beat, -> LOAD.
- Swap rule: the pixel sampled on the iFval rising-edge cycle and all later pixels use the new bank (read-bank mux uses next bank_sel that cycle). No frame ever mixes tables.
- Apply path: stage 1 reads LUT[bank][iGrey]; stage 2 registers oGrey. oGrey = LUT value if lut_valid, else iGrey (bypass); oGrey = 0 when delayed Dval = 0.
- CALC duration per table: 256×(CDF_W+10) cycles = 7680 at CDF_W=20. PEND absorbs frames that start earlier; calc may span frames.

## Timing
- Reset (iRST_N=0 at a clock edge): state IDLE, bank_sel 0, lut_valid 0, oGrey 0, oDval 0, oFval 0, oLut_Ready 0, oBusy 0, oState 0, pipeline cleared. Reset mid-LOAD/CALC aborts; RAM contents are don't-care because lut_valid=0 forces bypass.
- Pixel latency: exactly 2 cycles from iGrey/iDval/iFval to oGrey/oDval/oFval, every cycle, independent of FSM.
- oLut_Ready asserts in the cycle after the iFval rising-edge sample, coincident with bank_sel update.
- oBusy/oState are registered and reflect the current state.
- CDF beat and LUT write paths never collide with the read path: separate banks.

## Test plan
- Reset then stream ramp iGrey=0..255 with Dval=1 and no CDF: oGrey equals iGrey 2 cycles later; oLut_Ready never pulses.
- Uniform CDF (bin k = (k+1)*1200, denom 307200), wait PEND, raise iFval: oLut_Ready pulses once; iGrey=0 -> 0, 127 -> 127, 255 -> 255.
- Step CDF (bins 0..99 = 0, bins 100..255 = 1000, denom 1000): iGrey 50 -> 0, iGrey 100..255 -> 255.
- Denom 0 (all bins 0): after swap, oGrey = iGrey for all 256 values.
- iFval rises during CALC: the frame uses the old table; swap occurs at the next iFval rise after PEND entry; the boundary pixel uses the new value.
- iRST_N low for 1 cycle mid-CALC: state 0, bypass resumes; new CDF stream then completes normally.
